// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO burst reader.
package shared_pkg;

    typedef enum logic [1:0] {RD_IDLE, RD_BURST, RD_DRAIN, RD_DONE} rd_state_e;

    localparam int unsigned FIFO_RD_LATENCY = 1;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Control, FIFO read-port and output-stream signals of the burst reader.
// FIFO_BURST_READER_CHECKSUM_EN adds the checksum signal.
interface fifo_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
);

    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  busy;
    logic                  done;
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [LEN_WIDTH-1:0]  rd_count;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    modport master (
        input  start, burst_len, fifo_empty, fifo_data_out, m_ready,
`ifdef FIFO_BURST_READER_CHECKSUM_EN
        output checksum,
`endif
        output busy, done, fifo_rd_en, m_valid, m_data, rd_count
    );

    modport slave (
        output start, burst_len, fifo_empty, fifo_data_out, m_ready,
`ifdef FIFO_BURST_READER_CHECKSUM_EN
        input  checksum,
`endif
        input  busy, done, fifo_rd_en, m_valid, m_data, rd_count
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer that absorbs the FIFO read latency; head is the
// oldest word and stays put until popped.
module fifo_reader_skid #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            buf_cnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  pop_ok, push_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        pop_ok  = pop && (cnt_q != 2'd0);
        push_ok = push && ((cnt_q != 2'd2) || pop_ok);
        unique case ({push_ok, pop_ok})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever survives the pop.
                if (cnt_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign buf_cnt = cnt_q;
    assign head    = head_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops burst_len words from the FIFO and streams them out.
// FIFO_BURST_READER_CHECKSUM_EN adds an XOR checksum of the transferred words.
module fifo_burst_reader
    import shared_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input logic                 clk,
    input logic                 rst,
    fifo_burst_reader_if.master bus
);

    localparam int unsigned BUF_DEPTH = FIFO_RD_LATENCY + 1;

    rd_state_e             state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  rd_count_q;
    logic                  inflight_q;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  start_ok;
    logic                  xfer;
    logic                  rd_en;
    logic [2:0]            occupancy;

    assign start_ok = (state_q == RD_IDLE) && bus.start;
    assign xfer     = bus.m_valid && bus.m_ready;

    // Words buffered or in flight after this cycle's pop; never exceeds the buffer depth.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, xfer};
    assign rd_en     = (state_q == RD_BURST) && !bus.fifo_empty && (issued_q < len_q)
                       && (occupancy < 3'(BUF_DEPTH));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.burst_len != '0) ? RD_BURST : RD_DONE;
                end
            end
            RD_BURST: begin
                if (issued_q == len_q) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if ((rd_count_q + LEN_WIDTH'(xfer)) == len_q) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            rd_count_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (start_ok) begin
                len_q      <= bus.burst_len;
                issued_q   <= '0;
                rd_count_q <= '0;
            end else begin
                if (rd_en) begin
                    issued_q <= issued_q + LEN_WIDTH'(1);
                end
                if (xfer) begin
                    rd_count_q <= rd_count_q + LEN_WIDTH'(1);
                end
            end
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(bus.fifo_data_out),
        .pop      (xfer),
        .buf_cnt  (buf_cnt),
        .head     (buf_head)
    );

    assign bus.busy       = (state_q != RD_IDLE);
    assign bus.done       = (state_q == RD_DONE);
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (buf_cnt != 2'd0);
    assign bus.m_data     = buf_head;
    assign bus.rd_count   = rd_count_q;

`ifdef FIFO_BURST_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (xfer) begin
            checksum_q <= checksum_q ^ bus.m_data;
        end
    end

    assign bus.checksum = checksum_q;
`endif

endmodule
